// File: rtl/sha3_squeeze_streamer_if.sv
// Bus bundle for the SHA3 squeeze streamer: Keccak state capture side plus the
// AXI-Stream digest output. The streamer uses the master modport.
interface sha3_squeeze_streamer_if #(
   parameter int DATA_WIDTH = 16
);
   logic [1599:0]           Din;
   logic                    Din_valid;
   logic                    Din_ready;
   logic [2:0]              TUSER_in;
   logic [15:0]             out_len;
   logic                    squeeze_req;
   logic [DATA_WIDTH-1:0]   TDATA;
   logic [DATA_WIDTH/8-1:0] TKEEP;
   logic                    TVALID;
   logic                    TREADY;
   logic                    TLAST;

   modport master (
      input  Din, Din_valid, TUSER_in, out_len, TREADY,
      output Din_ready, squeeze_req, TDATA, TKEEP, TVALID, TLAST
   );

   modport slave (
      output Din, Din_valid, TUSER_in, out_len, TREADY,
      input  Din_ready, squeeze_req, TDATA, TKEEP, TVALID, TLAST
   );
endinterface

// File: rtl/sha3_squeeze_streamer.sv
// Streams a captured Keccak state as SHA3/SHAKE digest beats over AXI-Stream,
// requesting further permutations when a SHAKE block has been fully squeezed.
module sha3_squeeze_streamer #(
   parameter int DATA_WIDTH = 16,
   parameter bit BSWAP      = 1'b0
) (
   input logic                   ACLK,
   input logic                   ARESET,
   sha3_squeeze_streamer_if.master s
);
   localparam int         B   = DATA_WIDTH / 8;
   localparam logic [15:0] B16 = 16'(B);
   localparam logic [7:0]  B8  = 8'(B);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] SEND     = 2'd1;
   localparam logic [1:0] SQZ_WAIT = 2'd2;

   logic [1:0]     state;
   logic [2:0]     mode;
   logic [15:0]    rem;
   logic [7:0]     blk;
   logic           sqz;
   logic [1599:0]  lanes;
   logic [B-1:0]   keep_raw;
   logic           last_beat;
   logic           beat_ok;
   logic           block_end;

   function automatic logic [15:0] digest_len(input logic [2:0] sel, input logic [15:0] len);
      case (sel)
         3'd0:       return 16'd28;
         3'd2:       return 16'd48;
         3'd3:       return 16'd64;
         3'd4, 3'd5: return len;
         3'd7:       return 16'd200;
         default:    return 16'd32;
      endcase
   endfunction

   function automatic logic [7:0] rate(input logic [2:0] sel);
      case (sel)
         3'd4:    return 8'd168;
         3'd5:    return 8'd136;
         default: return 8'd200;
      endcase
   endfunction

   function automatic logic [15:0] sat_sub(input logic [15:0] a, input logic [15:0] b);
      return (a > b) ? (a - b) : 16'd0;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] swap_bytes(input logic [DATA_WIDTH-1:0] d);
      logic [DATA_WIDTH-1:0] r;
      r = d;
      if (BSWAP)
         for (int j = 0; j < B; j++) r[8*(B-1-j) +: 8] = d[8*j +: 8];
      return r;
   endfunction

   function automatic logic [B-1:0] swap_keep(input logic [B-1:0] k);
      logic [B-1:0] r;
      r = k;
      if (BSWAP)
         for (int j = 0; j < B; j++) r[B-1-j] = k[j];
      return r;
   endfunction

   // Partial keep only when fewer than B digest bytes remain.
   always_comb begin
      keep_raw = '1;
      if (rem < B16)
         for (int j = 0; j < B; j++) keep_raw[j] = (16'(j) < rem);
   end

   assign last_beat     = (rem <= B16);
   assign block_end     = ({1'b0, blk} + 9'(B)) == {1'b0, rate(mode)};
   assign s.TVALID      = (state == SEND);
   assign s.TLAST       = s.TVALID && last_beat;
   assign s.TKEEP       = s.TVALID ? swap_keep(keep_raw) : '0;
   assign s.TDATA       = s.TVALID ? swap_bytes(lanes[DATA_WIDTH-1:0]) : '0;
   assign s.Din_ready   = (state != SEND);
   assign s.squeeze_req = sqz;
   assign beat_ok       = s.TVALID && s.TREADY;

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state <= IDLE;
         mode  <= 3'd0;
         rem   <= 16'd0;
         blk   <= 8'd0;
         sqz   <= 1'b0;
      end else begin
         sqz <= 1'b0;
         case (state)
            IDLE: begin
               if (s.Din_valid) begin
                  mode <= s.TUSER_in;
                  rem  <= digest_len(s.TUSER_in, s.out_len);
                  blk  <= 8'd0;
                  // A zero-length SHAKE request is consumed without leaving IDLE.
                  if (digest_len(s.TUSER_in, s.out_len) != 16'd0) state <= SEND;
               end
            end
            SEND: begin
               if (beat_ok) begin
                  rem <= sat_sub(rem, B16);
                  blk <= blk + B8;
                  if (last_beat) begin
                     state <= IDLE;
                  end else if (block_end) begin
                     state <= SQZ_WAIT;
                     sqz   <= 1'b1;
                  end
               end
            end
            SQZ_WAIT: begin
               if (s.Din_valid) begin
                  blk   <= 8'd0;
                  state <= SEND;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // The state is shifted down one beat per handshake so the output is always the low bytes.
   always_ff @(posedge ACLK) begin
      if (s.Din_valid && s.Din_ready) lanes <= s.Din;
      else if (beat_ok)               lanes <= lanes >> DATA_WIDTH;
   end
endmodule
